z80_bus_cycle_decoder: RTL and testbench
========================================

Name: z80_bus_cycle_decoder

Overview:
- Sits directly downstream of the external-Z80 bus wrapper. Consumes its m1_n/mreq_n/iorq_n/rd_n/wr_n/A/dout outputs and returns read data on di.
- External Z80 strobes are asynchronous to clk. This block synchronises them and classifies each bus cycle as memory read, memory write, IO read, IO write or interrupt acknowledge.
- It issues one req/ack transaction per cycle to the memory/IO fabric and holds read data stable until the Z80 ends the cycle.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the control-strobe synchronisers; legal range 2..4.
- TIMEOUT, 255, clk cycles allowed in REQ before the cycle is forced to complete; 8-bit counter.
- IDLE_BUS, 8'hFF, data returned on di for timed-out reads and for interrupt-acknowledge cycles.

Ports:
- clk  in  1  system clock; Z80 bus sampled on rising edge.
- rst  in  1  synchronous reset, active-high.
- m1_n  in  1  Z80 M1 from wrapper, asynchronous.
- mreq_n  in  1  Z80 MREQ from wrapper, asynchronous.
- iorq_n  in  1  Z80 IORQ from wrapper, asynchronous.
- rd_n  in  1  Z80 RD from wrapper, asynchronous.
- wr_n  in  1  Z80 WR from wrapper, asynchronous.
- A  in  16  Z80 address from wrapper.
- dout  in  8  data driven by Z80, valid during writes.
- di  out  8  read data returned to wrapper.
- req  out  1  transaction request to memory/IO fabric.
- req_type  out  3  0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 int ack; 5..7 unused.
- req_addr  out  16  address latched at cycle start.
- req_wdata  out  8  write data latched at cycle start.
- ack  in  1  one-clk completion from fabric.
- rdata  in  8  fabric read data, valid with ack.
- timeout  out  1  one-clk pulse when a request is abandoned.

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: di=8'hFF, req=0, req_type=0, req_addr=0, req_wdata=0, timeout=0. FSM=IDLE, timeout counter=0.
- Synchronisers are preset to 1 (inactive) on reset.
- Synchronisation: each of m1_n, mreq_n, iorq_n, rd_n and wr_n passes through SYNC_STAGES flops. A and dout are not synchronised; they are sampled only on a detected cycle start, when they are stable.
- Decode uses synchronised values only:
  - mem rd: !mreq & !rd
  - mem wr: !mreq & !wr
  - io rd: !iorq & !rd & m1
  - io wr: !iorq & !wr
  - int ack: !iorq & !m1
  - Int ack has priority over io rd.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - A valid decode latches req_type, req_addr=A and req_wdata=dout (dout is latched on reads too; don't-care).
  - Asserts req the next clk and moves to REQ.
  - A decode that is already active when leaving reset is ignored until the strobes deassert. The arm flag is set only after all of mreq/iorq/rd/wr are synchronised high.
- Int ack: no fabric request. di=IDLE_BUS and the FSM goes straight from IDLE to HOLD; req stays 0.
- REQ:
  - req is held high; the counter increments every clk.
  - On ack: req drops the same clk. For read types, di<=rdata. Counter clears; go to HOLD.
  - When the counter reaches TIMEOUT with no ack: req drops, timeout pulses 1 clk, reads get di<=IDLE_BUS, go to HOLD.
  - An ack arriving on the same clk as the timeout wins: no timeout pulse, rdata is used.
- HOLD: di stays stable. Return to IDLE when the synchronised mreq_n and iorq_n are both high. No new cycle is accepted in the same clk.
- Strobes deasserting while in REQ (aborted cycle): stay in REQ until ack or timeout, then HOLD exits on the next clk. The fabric handshake is never broken.
- Outside HOLD, di keeps its last value. The wrapper only forwards di during read strobes.
- Latency:
  - Z80 strobe fall to req rise is SYNC_STAGES+1 clks.
  - ack to di valid is 1 clk.
  - Strobe rise to IDLE is SYNC_STAGES+1 clks.
- rst asserted in any state returns every output to its reset value on the next edge. A pending fabric request is dropped without waiting for ack.
- Counter width is 8 bits and saturates. TIMEOUT=0 times out on the first REQ clk unless ack is present.

Test Plan:
- Mem read: mreq_n=0, rd_n=0, A=16'h4000. Fabric acks 3 clks after req with rdata=8'hA5 -> req_type=0, req_addr=16'h4000, req high 3 clks, di=8'hA5 until strobes rise, then IDLE.
- IO write: iorq_n=0, wr_n=0, A=16'h00FE, dout=8'h07. Ack after 1 clk -> req_type=3, req_wdata=8'h07, timeout stays 0, exactly one req pulse per cycle.
- Int ack: m1_n=0, iorq_n=0, rd_n=1 -> no req, req_type=4, di=8'hFF, return to IDLE once iorq_n rises.
- Timeout: mem read, ack never asserted, TIMEOUT=255 -> req high 255 clks, timeout pulses once, di=8'hFF.
- Same-clk ack/timeout: ack with rdata=8'h3C on the 255th REQ clk -> no timeout pulse, di=8'h3C.
- Reset cases:
  - rst pulsed mid-REQ -> all outputs at reset values next clk.
  - Strobes held low through reset release -> no req until they rise and a fresh cycle starts.

Source files
------------

// File: rtl/z80_bus_cycle_decoder_if.sv
// z80_bus_cycle_decoder_if: Z80 wrapper strobes/data plus memory/IO fabric req/ack bundle
interface z80_bus_cycle_decoder_if;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] A;
  logic [7:0]  dout;
  logic [7:0]  di;
  logic        req;
  logic [2:0]  req_type;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        timeout;
  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, A, dout, ack, rdata,
    input  di, req, req_type, req_addr, req_wdata, timeout
  );
  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, A, dout, ack, rdata,
    output di, req, req_type, req_addr, req_wdata, timeout
  );
endinterface

// File: rtl/z80_bus_cycle_decoder.sv
// z80_bus_cycle_decoder: synchronises Z80 strobes, classifies bus cycles and runs one fabric req/ack per cycle
module z80_bus_cycle_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT     = 255,
  parameter logic [7:0] IDLE_BUS    = 8'hFF
) (
  input logic clk,
  input logic rst,
  z80_bus_cycle_decoder_if.slave bus
);
  localparam int SW = 5 * SYNC_STAGES;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  logic [SW-1:0] sync_q;
  logic m1_s, mreq_s, iorq_s, rd_s, wr_s;
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] fill_q, fill_d;
  logic armed_q, armed_d;
  logic req_q, req_d;
  logic [2:0] type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] di_q, di_d;
  logic to_q, to_d;
  logic dec_int, dec_mrd, dec_mwr, dec_ird, dec_iwr, dec_any;
  logic [2:0] dec_type;
  logic fill_done, expired, is_read;
  assign {m1_s, mreq_s, iorq_s, rd_s, wr_s} = sync_q[SW-1 -: 5];
  assign dec_int = !iorq_s & !m1_s;
  assign dec_mrd = !mreq_s & !rd_s;
  assign dec_mwr = !mreq_s & !wr_s;
  assign dec_ird = !iorq_s & !rd_s & m1_s;
  assign dec_iwr = !iorq_s & !wr_s;
  assign dec_any = dec_int | dec_mrd | dec_mwr | dec_ird | dec_iwr;
  assign dec_type = dec_int ? 3'd4 : dec_mrd ? 3'd0 : dec_mwr ? 3'd1 : dec_ird ? 3'd2 : 3'd3;
  assign fill_done = fill_q == 3'(SYNC_STAGES);
  assign expired = ({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT);
  assign is_read = (type_q == 3'd0) | (type_q == 3'd2);
  assign fill_d = fill_done ? fill_q : fill_q + 3'd1;
  // Arming waits until the synchroniser holds only post-reset samples, so presets cannot fake an idle bus
  assign armed_d = armed_q | (fill_done & mreq_s & iorq_s & rd_s & wr_s);
  always_comb begin
    state_d = state_q;
    cnt_d = 8'd0;
    req_d = req_q;
    type_d = type_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    di_d = di_q;
    to_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (armed_q && dec_any) begin
        type_d = dec_type;
        addr_d = bus.A;
        wdata_d = bus.dout;
        req_d = !dec_int;
        state_d = dec_int ? S_HOLD : S_REQ;
        di_d = dec_int ? IDLE_BUS : di_q;
      end
    end else if (state_q == S_REQ) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      if (bus.ack || expired) begin
        cnt_d = 8'd0;
        req_d = 1'b0;
        to_d = !bus.ack;
        state_d = S_HOLD;
        di_d = !is_read ? di_q : bus.ack ? bus.rdata : IDLE_BUS;
      end
    end else begin
      state_d = (mreq_s && iorq_s) ? S_IDLE : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      state_q <= S_IDLE;
      cnt_q <= 8'd0;
      fill_q <= 3'd0;
      armed_q <= 1'b0;
      req_q <= 1'b0;
      type_q <= 3'd0;
      addr_q <= 16'd0;
      wdata_q <= 8'd0;
      di_q <= 8'hFF;
      to_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SW-6:0], bus.m1_n, bus.mreq_n, bus.iorq_n, bus.rd_n, bus.wr_n};
      state_q <= state_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      armed_q <= armed_d;
      req_q <= req_d;
      type_q <= type_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      di_q <= di_d;
      to_q <= to_d;
    end
  end
  assign bus.di = di_q;
  assign bus.req = req_q;
  assign bus.req_type = type_q;
  assign bus.req_addr = addr_q;
  assign bus.req_wdata = wdata_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_z80_bus_cycle_decoder.sv
// tb_z80_bus_cycle_decoder: directed Z80 bus cycles checked against a transaction-level model every clock
module tb_z80_bus_cycle_decoder;
  localparam int S = 2;
  localparam int TO = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  z80_bus_cycle_decoder_if bus();
  z80_bus_cycle_decoder #(.SYNC_STAGES(S), .TIMEOUT(TO), .IDLE_BUS(8'hFF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int req_hi = 0;
  int to_cnt = 0;
  int req_rise = 0;
  logic prev_req = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  // model: strobes seen by the decoder are the raw samples from S clocks ago
  logic [4:0] hist [4];
  int since_rst, phase, n;
  bit armed, mvalid;
  logic [7:0] m_di, m_wd;
  logic m_req, m_to;
  logic [2:0] m_type;
  logic [15:0] m_addr;
  task automatic model_step();
    logic m1, mq, io, rd, wr;
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] = 5'h1F;
      since_rst = 0; phase = 0; n = 0; armed = 0; mvalid = 1;
      m_di = 8'hFF; m_wd = 0; m_req = 0; m_to = 0; m_type = 0; m_addr = 0;
      return;
    end
    {m1, mq, io, rd, wr} = hist[S-1];
    m_to = 0;
    if (phase == 0) begin
      if (armed && ((!io && !m1) || (!mq && (!rd || !wr)) || (!io && (!rd || !wr)))) begin
        m_type = (!io && !m1) ? 3'd4 : (!mq && !rd) ? 3'd0 : (!mq && !wr) ? 3'd1 : !rd ? 3'd2 : 3'd3;
        m_addr = bus.A;
        m_wd = bus.dout;
        if (m_type == 3'd4) begin
          m_di = 8'hFF; phase = 2;
        end else begin
          m_req = 1; phase = 1; n = 0;
        end
      end
    end else if (phase == 1) begin
      n++;
      if (bus.ack || n >= TO) begin
        m_req = 0; phase = 2; m_to = !bus.ack;
        if (m_type == 3'd0 || m_type == 3'd2) m_di = bus.ack ? bus.rdata : 8'hFF;
      end
    end else if (mq && io) phase = 0;
    if (since_rst >= S && mq && io && rd && wr) armed = 1;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {bus.m1_n, bus.mreq_n, bus.iorq_n, bus.rd_n, bus.wr_n};
    since_rst++;
  endtask
  always @(posedge clk) begin
    model_step();
    #1;
    if (mvalid) begin
      chk("req", bus.req, m_req);
      chk("req_type", bus.req_type, m_type);
      chk("req_addr", bus.req_addr, m_addr);
      chk("req_wdata", bus.req_wdata, m_wd);
      chk("di", bus.di, m_di);
      chk("timeout", bus.timeout, m_to);
    end
    req_hi += int'(bus.req === 1'b1);
    to_cnt += int'(bus.timeout === 1'b1);
    if (bus.req === 1'b1 && !prev_req) req_rise++;
    prev_req = (bus.req === 1'b1);
  end
  task automatic clr();
    req_hi = 0; to_cnt = 0; req_rise = 0;
  endtask
  task automatic release_bus();
    bus.m1_n = 1; bus.mreq_n = 1; bus.iorq_n = 1; bus.rd_n = 1; bus.wr_n = 1;
    repeat (6) @(negedge clk);
  endtask
  task automatic wait_req(input string nm, output int k);
    k = 0;
    while (bus.req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, bus.req, 1);
  endtask
  initial begin
    int k;
    bus.m1_n = 1; bus.mreq_n = 1; bus.iorq_n = 1; bus.rd_n = 1; bus.wr_n = 1;
    bus.A = 0; bus.dout = 0; bus.ack = 0; bus.rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_di", bus.di, 8'hFF);
    chk("rst_req", bus.req, 0);
    chk("rst_type", bus.req_type, 0);
    chk("rst_addr", bus.req_addr, 0);
    chk("rst_wdata", bus.req_wdata, 0);
    chk("rst_timeout", bus.timeout, 0);
    rst = 0;
    repeat (6) @(negedge clk);
    clr(); bus.A = 16'h4000; bus.dout = 8'h11; bus.mreq_n = 0; bus.rd_n = 0;
    wait_req("mrd_req", k);
    chk("mrd_latency", k, S + 1);
    repeat (2) @(negedge clk);
    bus.ack = 1; bus.rdata = 8'hA5;
    @(negedge clk);
    bus.ack = 0; bus.rdata = 8'h00;
    chk("mrd_req_drop", bus.req, 0);
    chk("mrd_di", bus.di, 8'hA5);
    chk("mrd_type", bus.req_type, 0);
    chk("mrd_addr", bus.req_addr, 16'h4000);
    chk("mrd_req_clks", req_hi, 3);
    chk("model_mrd_di", m_di, 8'hA5);
    repeat (4) @(negedge clk);
    chk("mrd_hold_di", bus.di, 8'hA5);
    release_bus();
    clr(); bus.A = 16'h00FE; bus.dout = 8'h07; bus.iorq_n = 0; bus.wr_n = 0;
    wait_req("iow_req", k);
    bus.ack = 1;
    @(negedge clk);
    bus.ack = 0;
    repeat (4) @(negedge clk);
    chk("iow_type", bus.req_type, 3);
    chk("iow_wdata", bus.req_wdata, 8'h07);
    chk("iow_addr", bus.req_addr, 16'h00FE);
    chk("iow_timeout", to_cnt, 0);
    chk("iow_one_req", req_rise, 1);
    chk("iow_req_clks", req_hi, 1);
    chk("iow_di_kept", bus.di, 8'hA5);
    release_bus();
    clr(); bus.A = 16'h0038; bus.m1_n = 0; bus.iorq_n = 0;
    repeat (6) @(negedge clk);
    chk("inta_type", bus.req_type, 4);
    chk("inta_di", bus.di, 8'hFF);
    chk("inta_no_req", req_rise, 0);
    chk("model_inta_type", m_type, 4);
    release_bus();
    clr(); bus.A = 16'h2000; bus.mreq_n = 0; bus.rd_n = 0;
    wait_req("same_req", k);
    repeat (TO - 1) @(negedge clk);
    bus.ack = 1; bus.rdata = 8'h3C;
    @(negedge clk);
    bus.ack = 0; bus.rdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("same_no_timeout", to_cnt, 0);
    chk("same_di", bus.di, 8'h3C);
    chk("same_req_clks", req_hi, TO);
    chk("same_type", bus.req_type, 0);
    release_bus();
    clr(); bus.A = 16'h1234; bus.mreq_n = 0; bus.rd_n = 0;
    wait_req("to_req", k);
    k = 0;
    while (bus.req === 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("to_req_fall", bus.req, 0);
    repeat (2) @(negedge clk);
    chk("to_pulses", to_cnt, 1);
    chk("to_req_clks", req_hi, TO);
    chk("to_di", bus.di, 8'hFF);
    chk("to_one_req", req_rise, 1);
    release_bus();
    clr(); bus.A = 16'h8001; bus.dout = 8'h55; bus.mreq_n = 0; bus.wr_n = 0;
    wait_req("rr_req", k);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rr_req", bus.req, 0);
    chk("rr_di", bus.di, 8'hFF);
    chk("rr_type", bus.req_type, 0);
    chk("rr_addr", bus.req_addr, 0);
    chk("rr_wdata", bus.req_wdata, 0);
    chk("rr_timeout", bus.timeout, 0);
    rst = 0;
    clr();
    repeat (10) @(negedge clk);
    chk("rr_held_no_req", req_rise, 0);
    release_bus();
    clr(); bus.A = 16'h0010; bus.wr_n = 1; bus.mreq_n = 0; bus.rd_n = 0;
    wait_req("rr_fresh_req", k);
    bus.ack = 1; bus.rdata = 8'h5A;
    @(negedge clk);
    bus.ack = 0; bus.rdata = 8'h00;
    chk("rr_fresh_di", bus.di, 8'h5A);
    chk("rr_fresh_addr", bus.req_addr, 16'h0010);
    chk("rr_fresh_one_req", req_rise, 1);
    release_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
